// File: rtl/tc_bitmem_scan_reader.sv
// tc_bitmem_scan_reader
//   Read-side master for a bank of single-bit cells on one pulled-down line.
//   A scan strobes cell_load for each cell in turn, waits SETTLE_CYCLES, then
//   samples cell_bit into word_data[idx]. The finished word is held in DONE
//   until the consumer takes it with word_valid && word_ready.
//   Optional build macro: TC_BITMEM_READER_PARITY_EN scans one extra parity
//   cell at index WIDTH and reports a stored-parity mismatch on parity_err.
//   Handshake: word_data/parity_err are stable while word_valid is high; the
//   word is transferred on a posedge where word_valid && word_ready, after
//   which the block returns to IDLE. word_ready is ignored at all other times.
//   dbg_state exposes the FSM state for debug and checker binding.
module tc_bitmem_scan_reader #(
  parameter int WIDTH         = 8,
  parameter int SETTLE_CYCLES = 1,
  localparam int SEL_W        = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  output logic             busy,
  output logic [SEL_W-1:0] cell_sel,
  output logic             cell_load,
  input  logic             cell_bit,
  output logic             word_valid,
  input  logic             word_ready,
  output logic [WIDTH-1:0] word_data,
  output logic             parity_err,
  output logic [2:0]       dbg_state
);

`ifdef TC_BITMEM_READER_PARITY_EN
  localparam int LAST = WIDTH;
`else
  localparam int LAST = WIDTH - 1;
`endif
  localparam logic [SEL_W-1:0] LAST_SEL = SEL_W'(LAST);

  // Settle counter is at least one bit wide so SETTLE_CYCLES=0 still elaborates.
  localparam int CNT_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((SETTLE_CYCLES > 0) ? SETTLE_CYCLES - 1 : 0);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    STROBE = 3'd1,
    SETTLE = 3'd2,
    SAMPLE = 3'd3,
    DONE   = 3'd4
  } state_t;

  state_t             state_q, state_d;
  logic [SEL_W-1:0]   idx_q, idx_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0]   word_q, word_d;
  logic               perr_q, perr_d;
  logic               bit_s;

  // A floating or unknown line reads as 0; only a driven 1 counts.
  assign bit_s = (cell_bit === 1'b1);

  // State and datapath registers; reset abandons any scan in progress.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      idx_q   <= '0;
      cnt_q   <= '0;
      word_q  <= '0;
      perr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      word_q  <= word_d;
      perr_q  <= perr_d;
    end
  end

  // Next-state logic: strobe, settle, sample each cell, then hold the word.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    word_d  = word_q;
    perr_d  = perr_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          word_d  = '0;
          idx_d   = '0;
          perr_d  = 1'b0;
          state_d = STROBE;
        end
      end
      STROBE: begin
        cnt_d   = '0;
        state_d = (SETTLE_CYCLES == 0) ? SAMPLE : SETTLE;
      end
      SETTLE: begin
        if (cnt_q == CNT_LAST) state_d = SAMPLE;
        else                   cnt_d   = cnt_q + 1'b1;
      end
      SAMPLE: begin
        // The parity cell (idx == WIDTH) matches no data bit and leaves word_q alone.
        for (int k = 0; k < WIDTH; k++) begin
          if (idx_q == SEL_W'(k)) word_d[k] = bit_s;
        end
        if (idx_q == LAST_SEL) begin
          state_d = DONE;
`ifdef TC_BITMEM_READER_PARITY_EN
          perr_d  = (^word_q) ^ bit_s;
`endif
        end else begin
          idx_d   = idx_q + 1'b1;
          state_d = STROBE;
        end
      end
      DONE: begin
        if (word_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Outputs decode directly from the registered state.
  always_comb begin
    busy       = (state_q != IDLE);
    cell_load  = (state_q == STROBE);
    word_valid = (state_q == DONE);
    cell_sel   = (state_q == STROBE || state_q == SETTLE || state_q == SAMPLE) ? idx_q : '0;
    word_data  = word_q;
    parity_err = perr_q;
    dbg_state  = state_q;
  end

endmodule

// File: tb/tb_tc_bitmem_scan_reader.sv
// tb_tc_bitmem_scan_reader
//   Bench for tc_bitmem_scan_reader with a behavioural cell bank on the
//   shared line. Build with +define+TC_BITMEM_READER_PARITY_EN for parity.
module tb_tc_bitmem_scan_reader;

  localparam int W     = 8;
  localparam int S     = 1;
  localparam int SEL_W = $clog2(W + 1);
`ifdef TC_BITMEM_READER_PARITY_EN
  localparam int PEN = 1;
`else
  localparam int PEN = 0;
`endif
  localparam int NCELL = W + PEN;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic             start = 1'b0;
  logic             busy;
  logic [SEL_W-1:0] cell_sel;
  logic             cell_load;
  wire              cell_bit;
  logic             word_valid;
  logic             word_ready = 1'b0;
  logic [W-1:0]     word_data;
  logic             parity_err;
  logic [2:0]       dbg_state;

  tc_bitmem_scan_reader #(.WIDTH(W), .SETTLE_CYCLES(S)) dut (
    .clk(clk), .rst(rst), .start(start), .busy(busy),
    .cell_sel(cell_sel), .cell_load(cell_load), .cell_bit(cell_bit),
    .word_valid(word_valid), .word_ready(word_ready), .word_data(word_data),
    .parity_err(parity_err), .dbg_state(dbg_state)
  );

  // ---------------- cell bank model ----------------
  // A cell drives the line after its load strobe; z-masked cells float.
  logic [W:0]       mem   = '0;
  logic [W:0]       zmask = '0;
  logic [SEL_W-1:0] drv_sel;
  logic             drv_en;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      drv_en  <= 1'b0;
      drv_sel <= '0;
    end else if (cell_load) begin
      drv_en  <= 1'b1;
      drv_sel <= cell_sel;
    end
  end

  assign cell_bit = (drv_en && !zmask[drv_sel]) ? mem[drv_sel] : 1'bz;

  // ---------------- scoreboard ----------------
  int checks = 0;
  int errors = 0;
  logic [SEL_W-1:0] exp_q[$];
  logic [SEL_W-1:0] sel_q[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic apply_reset();
    rst = 1'b0;
    start = 1'b0;
    word_ready = 1'b0;
    repeat (3) @(negedge clk);
    #2 rst = 1'b1;
    @(negedge clk);
  endtask

  task automatic check_idle_outputs(input string pfx);
    check({pfx, "_busy"},       32'(busy),       32'd0);
    check({pfx, "_cell_load"},  32'(cell_load),  32'd0);
    check({pfx, "_word_valid"}, 32'(word_valid), 32'd0);
    check({pfx, "_word_data"},  32'(word_data),  32'd0);
    check({pfx, "_cell_sel"},   32'(cell_sel),   32'd0);
    check({pfx, "_parity_err"}, 32'(parity_err), 32'd0);
  endtask

  // One full scan: random start/ready noise while busy, hold in DONE, handshake.
  task automatic run_scan(input logic [W:0] m, input logic [W:0] z, input int hold);
    logic [W-1:0] exp_word;
    logic         exp_perr;
    logic         pbit;
    int           exp_lat;
    int           n;
    bit           timed_out;

    mem = m;
    zmask = z;
    for (int k = 0; k < W; k++) exp_word[k] = m[k] & ~z[k];
    pbit = m[W] & ~z[W];
    exp_perr = (PEN == 1) ? ((^exp_word) ^ pbit) : 1'b0;
    exp_lat = NCELL * (2 + S);
    exp_q.delete();
    sel_q.delete();
    for (int k = 0; k < NCELL; k++) exp_q.push_back(SEL_W'(k));

    @(negedge clk);
    start = 1'b1;
    n = 0;
    timed_out = 1'b0;
    forever begin
      @(negedge clk);
      if (word_valid) break;
      if (cell_load) sel_q.push_back(cell_sel);
      start = 1'($urandom_range(0, 1));
      word_ready = 1'($urandom_range(0, 1));
      n++;
      if (n > 1000) begin
        timed_out = 1'b1;
        break;
      end
    end
    start = 1'b0;
    word_ready = 1'b0;
    if (timed_out) begin
      check("word_valid_timeout", 32'd0, 32'd1);
      apply_reset();
      return;
    end

    check("latency", 32'(n), 32'(exp_lat));
    check("load_count", 32'(sel_q.size()), 32'(NCELL));
    for (int k = 0; k < NCELL && k < sel_q.size(); k++)
      check("sel_seq", 32'(sel_q[k]), 32'(exp_q[k]));
    check("word_data", 32'(word_data), 32'(exp_word));
    check("parity_err", 32'(parity_err), 32'(exp_perr));
    check("busy_done", 32'(busy), 32'd1);
    check("sel_done", 32'(cell_sel), 32'd0);

    for (int i = 0; i < hold; i++) begin
      start = 1'($urandom_range(0, 1));
      @(negedge clk);
      check("hold_valid", 32'(word_valid), 32'd1);
      check("hold_data", 32'(word_data), 32'(exp_word));
    end

    // Handshake with start asserted in the same cycle: start must be ignored.
    word_ready = 1'b1;
    start = 1'b1;
    @(negedge clk);
    word_ready = 1'b0;
    start = 1'b0;
    check("post_hs_busy", 32'(busy), 32'd0);
    check("post_hs_valid", 32'(word_valid), 32'd0);
    @(negedge clk);
    check("no_restart", 32'(busy), 32'd0);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int guard;
    apply_reset();
    check_idle_outputs("reset");

    // Async reset in the middle of a scan (cell 3 strobed).
    mem = 9'h1FF;
    zmask = '0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    guard = 0;
    while (!(cell_load && cell_sel == SEL_W'(3)) && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    check("reach_idx3", 32'(guard < 200), 32'd1);
    #2 rst = 1'b0;
    @(negedge clk);
    check_idle_outputs("midscan_rst");
    #2 rst = 1'b1;
    @(negedge clk);
    check("rst_release_idle", 32'(busy), 32'd0);

    run_scan({1'b0, 8'hA5}, '0, 10);
    run_scan(9'h1FF, 9'h004, 2);
    run_scan({1'b0, 8'h07}, '0, 0);
    run_scan({1'b1, 8'h07}, '0, 1);
    run_scan(9'h000, '0, 0);
    run_scan(9'h1FF, '0, 3);

    for (int t = 0; t < 15; t++)
      run_scan(9'($urandom), 9'($urandom & $urandom & $urandom), int'($urandom_range(0, 6)));

    // ---------------- final report ----------------
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
